// File: rtl/pending_encoder_8b3b.sv
// pending_encoder_8b3b: stores a multi-hot vector and emits the index of each set bit, one per handshake, in priority order.
module pending_encoder_8b3b #(
    parameter int N = 3,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2**N-1:0]  in_bits,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     out_idx,
    output logic             out_last,
    output logic             zero_err,
    output logic             busy
);
    localparam int W = 2**N;
    typedef enum logic {IDLE, SCAN} state_t;
    state_t state, state_nx;
    logic [W-1:0] pend, pend_nx;
    logic [N-1:0] sel;
    logic single, zero_nx;
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            pend     <= '0;
            zero_err <= 1'b0;
        end else begin
            state    <= state_nx;
            pend     <= pend_nx;
            zero_err <= zero_nx;
        end
    end
    // Later assignments win, so walk from the low-priority end toward the high-priority end.
    always_comb begin
        sel = '0;
        for (int i = 0; i < W; i++) begin
            int j;
            j = MSB_FIRST ? i : W - 1 - i;
            if (pend[j]) sel = j[N-1:0];
        end
        single = (pend != '0) && ((pend & (pend - 1'b1)) == '0);
    end
    always_comb begin
        state_nx = state;
        pend_nx  = pend;
        zero_nx  = 1'b0;
        if (state == IDLE) begin
            if (in_valid) begin
                zero_nx = (in_bits == '0);
                if (in_bits != '0) begin
                    pend_nx  = in_bits;
                    state_nx = SCAN;
                end
            end
        end else if (out_ready) begin
            pend_nx[sel] = 1'b0;
            state_nx     = single ? IDLE : SCAN;
        end
    end
    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == SCAN);
        busy      = (state == SCAN);
        out_idx   = out_valid ? sel : '0;
        out_last  = out_valid & single;
    end
endmodule

// File: tb/tb_pending_encoder_8b3b.sv
// tb_pending_encoder_8b3b: random and directed checks of both priority orders against a queue-based reference.
module tb_pending_encoder_8b3b;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic in_valid = 1'b0;
    logic [7:0] in_bits = '0;
    logic out_ready = 1'b1;
    logic in_ready_a, out_valid_a, out_last_a, zero_err_a, busy_a;
    logic in_ready_b, out_valid_b, out_last_b, zero_err_b, busy_b;
    logic [2:0] out_idx_a, out_idx_b;
    int n_cmp = 0;
    int n_err = 0;
    int q_lo[$];
    int q_hi[$];
    bit zx = 1'b0;

    always #5 clk = ~clk;

    pending_encoder_8b3b #(.N(3), .MSB_FIRST(1'b0)) dut_a (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_a), .in_bits(in_bits),
        .out_valid(out_valid_a), .out_ready(out_ready), .out_idx(out_idx_a), .out_last(out_last_a),
        .zero_err(zero_err_a), .busy(busy_a));

    pending_encoder_8b3b #(.N(3), .MSB_FIRST(1'b1)) dut_b (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_b), .in_bits(in_bits),
        .out_valid(out_valid_b), .out_ready(out_ready), .out_idx(out_idx_b), .out_last(out_last_b),
        .zero_err(zero_err_b), .busy(busy_b));

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: the pending set as ordered queues of indices still to be emitted.
    task automatic step();
        @(posedge clk);
        if (reset) begin
            q_lo.delete();
            q_hi.delete();
            zx = 1'b0;
        end else if (q_lo.size() == 0) begin
            zx = in_valid && (in_bits == 8'h00);
            if (in_valid && in_bits != 8'h00)
                for (int i = 0; i < 8; i++) begin
                    if (in_bits[i]) q_lo.push_back(i);
                    if (in_bits[7-i]) q_hi.push_back(7 - i);
                end
        end else begin
            zx = 1'b0;
            if (out_ready) begin
                void'(q_lo.pop_front());
                void'(q_hi.pop_front());
            end
        end
        #1;
        chk("in_ready_a", int'(in_ready_a), int'(q_lo.size() == 0));
        chk("in_ready_b", int'(in_ready_b), int'(q_hi.size() == 0));
        chk("busy_a", int'(busy_a), int'(q_lo.size() != 0));
        chk("busy_b", int'(busy_b), int'(q_hi.size() != 0));
        chk("out_valid_a", int'(out_valid_a), int'(q_lo.size() != 0));
        chk("out_valid_b", int'(out_valid_b), int'(q_hi.size() != 0));
        chk("out_idx_a", int'(out_idx_a), q_lo.size() != 0 ? q_lo[0] : 0);
        chk("out_idx_b", int'(out_idx_b), q_hi.size() != 0 ? q_hi[0] : 0);
        chk("out_last_a", int'(out_last_a), int'(q_lo.size() == 1));
        chk("out_last_b", int'(out_last_b), int'(q_hi.size() == 1));
        chk("zero_err_a", int'(zero_err_a), int'(zx));
        chk("zero_err_b", int'(zero_err_b), int'(zx));
    endtask

    task automatic send(input logic [7:0] v);
        in_valid = 1'b1;
        in_bits = v;
        step();
        in_valid = 1'b0;
        in_bits = 8'($urandom);
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (q_lo.size() != 0 && n < budget) begin
            step();
            n++;
        end
        chk("drain_timeout", int'(q_lo.size() == 0 && in_ready_a), 1);
    endtask

    initial begin
        step();
        step();
        reset = 1'b0;
        step();
        out_ready = 1'b1;
        send(8'b1010_0110);
        drain(12);
        step();
        send(8'b1000_0001);
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_bits = 8'($urandom);
            step();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        drain(12);
        send(8'h00);
        step();
        send(8'hFF);
        drain(12);
        send(8'b0100_1001);
        drain(12);
        for (int i = 0; i < 8; i++) begin
            send(8'(1 << i));
            drain(4);
        end
        send(8'hF0);
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
        step();
        for (int t = 0; t < 3000; t++) begin
            in_valid = ($urandom_range(0, 2) != 0);
            in_bits = ($urandom_range(0, 9) == 0) ? 8'h00 : 8'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            reset = ($urandom_range(0, 199) == 0);
            step();
        end
        reset = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        drain(12);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/pending_encoder_8b3b.md
Name: pending_encoder_8b3b

Overview:
- Sequential binary encoder, the inverse of the team's 3b-to-8b binary decoder.
- Accepts a multi-hot request vector, stores it, then emits the binary index of each set bit, one per output handshake, in priority order.
- Each emitted bit is cleared from the stored vector.
- Sits between event/interrupt flag collectors and consumers that need indices, e.g. a decoder select bus.

Parameters:
- N, 3, index width; vector width is 2**N (8 at default).
- MSB_FIRST, 0, 0 = lowest set bit served first; 1 = highest set bit served first.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  in_bits is valid this cycle.
- in_ready  output  1  block can accept a vector.
- in_bits  input  2**N  multi-hot request vector.
- out_valid  output  1  out_idx is valid.
- out_ready  input  1  consumer accepts out_idx.
- out_idx  output  N  binary index of the current highest-priority pending bit.
- out_last  output  1  current out_idx is the final pending bit of this vector.
- zero_err  output  1  one-cycle pulse: an all-zero vector was accepted.
- busy  output  1  state is SCAN.

Behaviour:
- Reset (synchronous, active-high, sampled on the rising edge of clk), to be asserted for at least one cycle:
  - Internal state: state=IDLE, pend='0.
  - Outputs: in_ready=1, out_valid=0, out_idx=0, out_last=0, zero_err=0, busy=0.
- Reset mid-SCAN discards all pending bits. The next cycle is IDLE with nothing emitted.
- Internal pending register pend[2**N-1:0].
- States: IDLE and SCAN.
- IDLE:
  - in_ready=1, out_valid=0, busy=0.
  - Input accepted when in_valid & in_ready at a clock edge.
  - Nonzero vector: pend<=in_bits, state<=SCAN.
  - in_bits==0: pend stays 0, state stays IDLE, zero_err=1 for exactly the following cycle.
- SCAN:
  - in_ready=0, busy=1, out_valid=1.
  - in_valid is ignored, i.e. in_bits is not sampled.
  - out_idx is the index of the lowest set bit of pend (MSB_FIRST=0) or the highest set bit (MSB_FIRST=1).
  - out_idx is a combinational function of the registered pend, so it is stable while out_valid & !out_ready.
  - out_last=1 iff pend has exactly one bit set (popcount==1).
- Output handshake:
  - Occurs when out_valid & out_ready at a clock edge.
  - pend bit out_idx is cleared.
  - If out_last was 1, state<=IDLE and pend becomes 0.
  - Otherwise the block stays in SCAN and the next index appears the following cycle.
- Latency:
  - Accept at edge t -> out_valid=1 in cycle t+1.
  - Throughput is one index per cycle while out_ready is held high.
  - Final handshake at edge t -> in_ready=1 in cycle t+1. There is no back-to-back accept on the same edge as the final handshake.
- Backpressure: with out_ready=0, out_valid, out_idx and out_last hold with no change.
- Whenever out_valid=0: out_idx=0 and out_last=0.
- A vector with k set bits produces exactly k output beats. Each index appears exactly once, in strictly increasing order (MSB_FIRST=0) or strictly decreasing order (MSB_FIRST=1).
- All-ones vector: 2**N beats. Indices 0..2**N-1 with MSB_FIRST=0.
- Generic in N: no width-specific constants. Priority select is a loop or function over 2**N bits.

Test Plan:
- Reset, then idle: reset=1 for 2 cycles, then 0 -> in_ready=1, out_valid=0, busy=0, out_idx=0, zero_err=0.
- Multi-bit, MSB_FIRST=0, out_ready=1: in_bits=8'b1010_0110 accepted -> out_idx sequence 1,2,5,7 on consecutive cycles. out_last=1 only on 7. in_ready=1 the cycle after.
- Backpressure: in_bits=8'b1000_0001, out_ready=0 for 4 cycles then 1 -> out_idx=0 held 4 cycles, then 0 accepted, then 7 with out_last=1. in_valid pulses with other data during SCAN are ignored.
- Zero and full vectors:
  - in_bits=8'h00 -> zero_err pulses 1 cycle, no out_valid, stays IDLE.
  - in_bits=8'hFF -> 8 beats, 0..7.
- MSB_FIRST=1 instance: in_bits=8'b0100_1001 -> out_idx 6,3,0. out_last only on 0.
- Sweep and reset mid-operation:
  - Every one-hot value i=0..7 -> single beat, out_idx=i, out_last=1, mirroring the decoder sweep.
  - Reset asserted after the first beat of 8'hF0 -> next cycle IDLE, out_valid=0, no further beats emitted.
